// File: rtl/core_pkg.sv
// core_pkg
//   Encodings shared across the MIPS core pipeline: the NOP register address,
//   the execute-stage NOP op code, the zero word, the stall-vector bit values,
//   and the action type decoded by each pipeline stage register.
package core_pkg;

  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
  localparam logic [7:0]  EXE_NOP_OP   = 8'h00;
  localparam logic [31:0] ZEROWORD     = 32'h0000_0000;

  // Stall vector bit values: 1 stops the stage.
  localparam logic STOP     = 1'b1;
  localparam logic NOT_STOP = 1'b0;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADVANCE,
    ACT_HOLD
  } stage_act_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter for performance monitoring. Stops at all-ones
//   rather than wrapping. clr zeroes the count and beats inc; rst beats both.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   inc      : count one event this cycle
//   clr      : zero the count this cycle
//   cnt      : current count
module sat_counter #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [PERF_W-1:0] cnt
);

  logic [PERF_W-1:0] r_cnt;
  logic              w_at_max;

  assign w_at_max = &r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg
//   EX->MEM pipeline register. Carries GPR writeback, HI/LO writeback and
//   load/store info with an explicit valid bit. Each cycle exactly one action
//   applies, highest priority first: RESET, FLUSH, ADVANCE (S=0),
//   BUBBLE (S=1,D=0), HOLD (S=1,D=1), where S/D are this stage's and the
//   downstream stage's stall bits. Multi-cycle arithmetic state (acc/cnt)
//   round-trips through here while EX stalls this stage.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   stall, flush        : core stall vector, exception flush of this stage
//   perf_clr            : clears both performance counters
//   ex_*                : payload from EX (valid, GPR/HI/LO writeback, ld/st)
//   acc_i, cnt_i        : multi-cycle state from EX
//   mem_*               : registered payload to MEM
//   acc_o, cnt_o        : multi-cycle state back to EX
//   bubble_cnt/hold_cnt : saturating bubble and hold cycle counts
module ex_mem_stage_reg
  import core_pkg::*;
#(
  parameter int              DATA_W  = 32,
  parameter int              ADDR_W  = 5,
  parameter int              OP_W    = 8,
  parameter int              CNT_W   = 2,
  parameter int              STALL_W = 6,
  parameter int              STAGE   = 3,
  parameter logic [OP_W-1:0] NOP_OP  = OP_W'(EXE_NOP_OP),
  parameter int              PERF_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                perf_clr,
  input  logic                ex_valid,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [ADDR_W-1:0]   ex_waddr,
  input  logic                ex_we,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_hilo_we,
  input  logic [OP_W-1:0]     ex_alu_op,
  input  logic [DATA_W-1:0]   ex_mem_addr,
  input  logic [DATA_W-1:0]   ex_operand_2,
  input  logic [2*DATA_W-1:0] acc_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic                mem_valid,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_hilo_we,
  output logic [OP_W-1:0]     mem_alu_op,
  output logic [DATA_W-1:0]   mem_mem_addr,
  output logic [DATA_W-1:0]   mem_operand_2,
  output logic [2*DATA_W-1:0] acc_o,
  output logic [CNT_W-1:0]    cnt_o,
  output logic [PERF_W-1:0]   bubble_cnt,
  output logic [PERF_W-1:0]   hold_cnt
);

  logic                w_s;
  logic                w_d;
  logic                w_unused_stall;
  stage_act_e          w_act;

  logic                r_valid;
  logic [DATA_W-1:0]   r_wdata;
  logic [ADDR_W-1:0]   r_waddr;
  logic                r_we;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_hilo_we;
  logic [OP_W-1:0]     r_alu_op;
  logic [DATA_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_operand_2;
  logic [2*DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]    r_cnt;

  assign w_s = stall[STAGE];
  assign w_d = stall[STAGE+1];
  // Only two bits of the shared stall vector belong to this stage.
  assign w_unused_stall = ^stall;

  // Action decode: flush beats every stall pattern; rst beats everything.
  always_comb begin
    w_act = ACT_HOLD;
    if (rst) begin
      w_act = ACT_RESET;
    end else if (flush) begin
      w_act = ACT_FLUSH;
    end else if (w_s == NOT_STOP) begin
      w_act = ACT_ADVANCE;
    end else if (w_d == NOT_STOP) begin
      w_act = ACT_BUBBLE;
    end else begin
      w_act = ACT_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    case (w_act)
      ACT_ADVANCE: begin
        r_valid     <= ex_valid;
        r_wdata     <= ex_wdata;
        r_waddr     <= ex_waddr;
        // An invalid slot must never write architectural state.
        r_we        <= ex_we & ex_valid;
        r_hi        <= ex_hi;
        r_lo        <= ex_lo;
        r_hilo_we   <= ex_hilo_we & ex_valid;
        r_alu_op    <= ex_alu_op;
        r_mem_addr  <= ex_mem_addr;
        r_operand_2 <= ex_operand_2;
      end
      ACT_HOLD: begin
      end
      default: begin
        r_valid     <= 1'b0;
        r_wdata     <= DATA_W'(ZEROWORD);
        r_waddr     <= ADDR_W'(NOP_REG_ADDR);
        r_we        <= 1'b0;
        r_hi        <= DATA_W'(ZEROWORD);
        r_lo        <= DATA_W'(ZEROWORD);
        r_hilo_we   <= 1'b0;
        r_alu_op    <= NOP_OP;
        r_mem_addr  <= DATA_W'(ZEROWORD);
        r_operand_2 <= DATA_W'(ZEROWORD);
      end
    endcase

    // Multi-cycle state survives only while this stage is stalled; the
    // first non-stalled cycle (or a flush/reset) aborts or retires it.
    if (w_act == ACT_BUBBLE || w_act == ACT_HOLD) begin
      r_acc <= acc_i;
      r_cnt <= cnt_i;
    end else begin
      r_acc <= '0;
      r_cnt <= '0;
    end
  end

  sat_counter #(.PERF_W(PERF_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_act == ACT_BUBBLE),
    .clr (perf_clr),
    .cnt (bubble_cnt)
  );

  sat_counter #(.PERF_W(PERF_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_act == ACT_HOLD),
    .clr (perf_clr),
    .cnt (hold_cnt)
  );

  assign mem_valid     = r_valid;
  assign mem_wdata     = r_wdata;
  assign mem_waddr     = r_waddr;
  assign mem_we        = r_we;
  assign mem_hi        = r_hi;
  assign mem_lo        = r_lo;
  assign mem_hilo_we   = r_hilo_we;
  assign mem_alu_op    = r_alu_op;
  assign mem_mem_addr  = r_mem_addr;
  assign mem_operand_2 = r_operand_2;
  assign acc_o         = r_acc;
  assign cnt_o         = r_cnt;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb_ex_mem_stage_reg
//   Scoreboard bench for ex_mem_stage_reg: a reference model computes the
//   next-edge outputs from the driven inputs, pushes them to a queue, and
//   they are popped and compared one time unit after the clock edge.
module tb_ex_mem_stage_reg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int OP_W    = 8;
  localparam int CNT_W   = 2;
  localparam int STALL_W = 6;
  localparam int STAGE   = 3;
  localparam int PERF_W  = 2;
  localparam logic [OP_W-1:0]   NOP     = 8'h00;
  localparam logic [PERF_W-1:0] PERF_MX = 2'd3;

  logic                clk = 1'b0;
  logic                rst, flush, perf_clr, ex_valid, ex_we, ex_hilo_we;
  logic [STALL_W-1:0]  stall;
  logic [DATA_W-1:0]   ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_operand_2;
  logic [ADDR_W-1:0]   ex_waddr;
  logic [OP_W-1:0]     ex_alu_op;
  logic [2*DATA_W-1:0] acc_i;
  logic [CNT_W-1:0]    cnt_i;

  logic                mem_valid, mem_we, mem_hilo_we;
  logic [DATA_W-1:0]   mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_operand_2;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [OP_W-1:0]     mem_alu_op;
  logic [2*DATA_W-1:0] acc_o;
  logic [CNT_W-1:0]    cnt_o;
  logic [PERF_W-1:0]   bubble_cnt, hold_cnt;

  always #5 clk = ~clk;

  ex_mem_stage_reg #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .CNT_W(CNT_W),
    .STALL_W(STALL_W), .STAGE(STAGE), .NOP_OP(NOP), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
    .ex_valid(ex_valid), .ex_wdata(ex_wdata), .ex_waddr(ex_waddr), .ex_we(ex_we),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_hilo_we(ex_hilo_we),
    .ex_alu_op(ex_alu_op), .ex_mem_addr(ex_mem_addr), .ex_operand_2(ex_operand_2),
    .acc_i(acc_i), .cnt_i(cnt_i),
    .mem_valid(mem_valid), .mem_wdata(mem_wdata), .mem_waddr(mem_waddr),
    .mem_we(mem_we), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_hilo_we(mem_hilo_we),
    .mem_alu_op(mem_alu_op), .mem_mem_addr(mem_mem_addr),
    .mem_operand_2(mem_operand_2), .acc_o(acc_o), .cnt_o(cnt_o),
    .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );

  typedef struct {
    logic                valid, we, hilo_we;
    logic [DATA_W-1:0]   wdata, hi, lo, maddr, op2;
    logic [ADDR_W-1:0]   waddr;
    logic [OP_W-1:0]     op;
    logic [2*DATA_W-1:0] acc;
    logic [CNT_W-1:0]    cnt;
    logic [PERF_W-1:0]   bub, hold;
  } exp_t;

  exp_t m;          // reference model state
  exp_t sb_q[$];    // scoreboard
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic nop_payload();
    m.valid = 1'b0; m.we = 1'b0; m.hilo_we = 1'b0; m.waddr = '0;
    m.wdata = '0; m.hi = '0; m.lo = '0; m.maddr = '0; m.op2 = '0;
    m.op = NOP;
  endtask

  // Next-edge model from the currently driven inputs.
  task automatic model_step();
    logic s, d;
    s = stall[STAGE];
    d = stall[STAGE+1];
    if (rst) begin
      nop_payload();
      m.acc = '0; m.cnt = '0; m.bub = '0; m.hold = '0;
    end else begin
      if (flush) begin
        nop_payload();
        m.acc = '0; m.cnt = '0;
      end else if (!s) begin
        m.valid = ex_valid; m.we = ex_we && ex_valid; m.hilo_we = ex_hilo_we && ex_valid;
        m.waddr = ex_waddr; m.wdata = ex_wdata; m.hi = ex_hi; m.lo = ex_lo;
        m.maddr = ex_mem_addr; m.op2 = ex_operand_2; m.op = ex_alu_op;
        m.acc = '0; m.cnt = '0;
      end else if (!d) begin
        nop_payload();
        m.acc = acc_i; m.cnt = cnt_i;
        if (!perf_clr && m.bub != PERF_MX) m.bub = m.bub + 1'b1;
      end else begin
        m.acc = acc_i; m.cnt = cnt_i;
        if (!perf_clr && m.hold != PERF_MX) m.hold = m.hold + 1'b1;
      end
      if (perf_clr) begin
        m.bub = '0; m.hold = '0;
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("valid",      mem_valid,   e.valid);
    chk("we",         mem_we,      e.we);
    chk("waddr",      mem_waddr,   e.waddr);
    chk("wdata",      mem_wdata,   e.wdata);
    chk("hilo",       {mem_hi, mem_lo, mem_hilo_we}, {e.hi, e.lo, e.hilo_we});
    chk("ldst",       {mem_alu_op, mem_mem_addr, mem_operand_2}, {e.op, e.maddr, e.op2});
    chk("acc_o",      acc_o,       e.acc);
    chk("cnt_o",      cnt_o,       e.cnt);
    chk("bubble_cnt", bubble_cnt,  e.bub);
    chk("hold_cnt",   hold_cnt,    e.hold);
  endtask

  // Other stall bits are randomised so a wrong bit index is exposed.
  task automatic set_stall(input logic s, input logic d);
    stall = STALL_W'($urandom);
    stall[STAGE]   = s;
    stall[STAGE+1] = d;
  endtask

  task automatic set_ex(input logic v, input logic we, input logic [ADDR_W-1:0] wa,
                        input logic [DATA_W-1:0] wd);
    ex_valid     = v;
    ex_we        = we;
    ex_waddr     = wa;
    ex_wdata     = wd;
    ex_hi        = $urandom;
    ex_lo        = $urandom;
    ex_hilo_we   = 1'($urandom);
    ex_alu_op    = OP_W'($urandom_range(1, 255));
    ex_mem_addr  = $urandom;
    ex_operand_2 = $urandom;
    acc_i        = {$urandom, $urandom};
    cnt_i        = CNT_W'($urandom);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; perf_clr = 1'b0;
    set_stall(1'b1, 1'b1);
    set_ex(1'b1, 1'b1, 5'd1, 32'h1111);
    cycle();
    cycle();
    rst = 1'b0;

    // Reset mid-hold
    set_stall(1'b0, 1'b0); set_ex(1'b1, 1'b1, 5'd9, 32'hDEADBEEF); cycle();
    set_stall(1'b1, 1'b1); set_ex(1'b1, 1'b1, 5'd3, 32'h00000BAD); cycle();
    rst = 1'b1; set_stall(1'b1, 1'b1); cycle();
    rst = 1'b0;

    // Advance
    set_stall(1'b0, 1'b0); set_ex(1'b1, 1'b1, 5'd5, 32'h1234); cycle();

    // Bubble with accumulator round-trip, then retire
    for (int i = 0; i < 3; i++) begin
      set_stall(1'b1, 1'b0); set_ex(1'b1, 1'b1, 5'd6, 32'h5555);
      acc_i = 64'((i + 1) * 16); cnt_i = CNT_W'(i + 1);
      cycle();
    end
    set_stall(1'b0, 1'b0); set_ex(1'b1, 1'b1, 5'd7, 32'hCAFE); cycle();

    // Flush beats stall on a held valid payload
    set_stall(1'b1, 1'b1); cycle();
    flush = 1'b1; set_stall(1'b1, 1'b1); cycle();
    set_stall(1'b1, 1'b0); cycle();
    set_stall(1'b0, 1'b0); cycle();
    flush = 1'b0;

    // Invalid slot gating
    set_stall(1'b0, 1'b0); set_ex(1'b0, 1'b1, 5'd12, 32'hF00D); ex_hilo_we = 1'b1; cycle();

    // Counter saturation, then clear beats increment
    for (int i = 0; i < 5; i++) begin
      set_stall(1'b1, 1'b0); set_ex(1'b1, 1'b1, 5'd2, 32'h2); cycle();
    end
    perf_clr = 1'b1; set_stall(1'b1, 1'b0); cycle();
    perf_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_stall(1'b1, 1'b1); cycle();
    end
    perf_clr = 1'b1; flush = 1'b1; cycle();
    perf_clr = 1'b0; flush = 1'b0;

    // Reset in the middle of a multi-cycle op
    set_stall(1'b1, 1'b0); acc_i = 64'hAAAA_0000_5555_FFFF; cnt_i = 2'd2; cycle();
    rst = 1'b1; set_stall(1'b1, 1'b0); cycle();
    rst = 1'b0;

    // Mixed random traffic
    for (int i = 0; i < 80; i++) begin
      rst      = ($urandom_range(0, 29) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      perf_clr = ($urandom_range(0, 15) == 0);
      set_stall(1'($urandom), 1'($urandom));
      set_ex(1'($urandom), 1'($urandom), ADDR_W'($urandom), $urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
